// File: rtl/md_lr_seqr.sv
// md_lr_seqr: top-level phase sequencer for the long-range (PME) engine.
//
// Runs a programmable number of timesteps. Each timestep clears the whole
// charge grid (INIT), waits for the first valid particle data (WAIT), then
// hands control to the phase engines in order PGMAP, FFTX, FFTY, FFTZNG,
// IFFTX, IFFTY, IFFTZ and (unless energy-only mode is selected) FCALC.
// Each phase is guarded by a watchdog; a hung phase parks the sequencer in
// ERROR until the next start or reset.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         run request pulse (ignored while busy)
//   num_steps     timesteps to run, latched on an accepted start (0 runs 1)
//   skip_fcalc    energy-only mode, latched on an accepted start
//   p_valid       first valid particle data available
//   phase_done    completion pulse from the active phase engine
//   state_o       current state code
//   phase_start   one-cycle pulse on entry to PGMAP..FCALC
//   gm_clr_we     grid memory clear write enable
//   gm_clr_addr   grid memory clear address
//   step_cnt      completed timesteps in the current run
//   busy          high in every state except IDLE and ERROR
//   done          one-cycle pulse when the run completes
//   err           sticky watchdog error flag
//   err_state     state that timed out
module md_lr_seqr #(
    parameter  int GX        = 32,
    parameter  int GY        = 32,
    parameter  int GZ        = 32,
    parameter  int STEP_W    = 16,
    parameter  int TMO_W     = 20,
    parameter  int TMO_LIMIT = 2**20 - 1,
    localparam int NPTS      = GX * GY * GZ,
    localparam int AW        = $clog2(NPTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              skip_fcalc,
    input  logic              p_valid,
    input  logic              phase_done,
    output logic [3:0]        state_o,
    output logic              phase_start,
    output logic              gm_clr_we,
    output logic [AW-1:0]     gm_clr_addr,
    output logic [STEP_W-1:0] step_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        err_state
);

    // Codes 0..9 follow te_md_lr_seqr_state; IDLE and ERROR occupy the
    // reserved top slots so the phase codes stay unchanged.
    typedef enum logic [3:0] {
        S_INIT   = 4'h0,
        S_WAIT   = 4'h1,
        S_PGMAP  = 4'h2,
        S_FFTX   = 4'h3,
        S_FFTY   = 4'h4,
        S_FFTZNG = 4'h5,
        S_IFFTX  = 4'h6,
        S_IFFTY  = 4'h7,
        S_IFFTZ  = 4'h8,
        S_FCALC  = 4'h9,
        S_ERROR  = 4'hE,
        S_IDLE   = 4'hF
    } state_t;

    state_t            state;
    state_t            nxt;
    state_t            succ;
    logic [TMO_W-1:0]  wdog;
    logic [STEP_W-1:0] steps_lat;
    logic              skip_lat;
    logic              phase_fin;
    logic              run_end;
    logic              step_last;
    logic              wd_hit;
    logic              accept;

    function automatic logic is_phase(input state_t s);
        return (s >= S_PGMAP) && (s <= S_FCALC);
    endfunction

    assign state_o = state;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        nxt       = state;
        succ      = S_IDLE;
        accept    = ((state == S_IDLE) || (state == S_ERROR)) && start;
        // The entry cycle is exactly the cycle phase_start is high, so a
        // done pulse there is ignored.
        phase_fin = is_phase(state) && !phase_start && phase_done;
        run_end   = phase_fin && ((state == S_FCALC) || (state == S_IFFTZ && skip_lat));
        step_last = (step_cnt + STEP_W'(1)) == steps_lat;
        // Counter holds the number of cycles already spent in the phase, so
        // the last permitted cycle is the one where it equals LIMIT-1.
        wd_hit    = (TMO_LIMIT != 0) && (wdog == TMO_W'(TMO_LIMIT - 1));

        case (state)
            S_PGMAP:  succ = S_FFTX;
            S_FFTX:   succ = S_FFTY;
            S_FFTY:   succ = S_FFTZNG;
            S_FFTZNG: succ = S_IFFTX;
            S_IFFTX:  succ = S_IFFTY;
            S_IFFTY:  succ = S_IFFTZ;
            S_IFFTZ:  succ = S_FCALC;
            default:  succ = S_IDLE;
        endcase

        case (state)
            S_IDLE, S_ERROR: if (start) nxt = S_INIT;
            S_INIT:          if (gm_clr_addr == AW'(NPTS - 1)) nxt = S_WAIT;
            S_WAIT:          if (p_valid) nxt = S_PGMAP;
            S_PGMAP, S_FFTX, S_FFTY, S_FFTZNG,
            S_IFFTX, S_IFFTY, S_IFFTZ, S_FCALC: begin
                // A completing phase beats a watchdog hit on the same cycle.
                if (run_end)        nxt = step_last ? S_IDLE : S_INIT;
                else if (phase_fin) nxt = succ;
                else if (wd_hit)    nxt = S_ERROR;
            end
            default:         nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            phase_start <= 1'b0;
            gm_clr_we   <= 1'b0;
            gm_clr_addr <= '0;
            step_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_state   <= '0;
            wdog        <= '0;
            steps_lat   <= '0;
            skip_lat    <= 1'b0;
        end else begin
            state       <= nxt;
            phase_start <= is_phase(nxt) && (nxt != state);
            gm_clr_we   <= (nxt == S_INIT);
            gm_clr_addr <= ((nxt == S_INIT) && (state == S_INIT)) ? gm_clr_addr + AW'(1) : '0;
            busy        <= (nxt != S_IDLE) && (nxt != S_ERROR);
            done        <= run_end && step_last;
            wdog        <= ((nxt == state) && is_phase(state)) ? wdog + TMO_W'(1) : '0;

            if (accept) begin
                steps_lat <= (num_steps == '0) ? STEP_W'(1) : num_steps;
                skip_lat  <= skip_fcalc;
                step_cnt  <= '0;
                err       <= 1'b0;
            end else if (run_end) begin
                step_cnt  <= step_cnt + STEP_W'(1);
            end

            if ((nxt == S_ERROR) && (state != S_ERROR)) begin
                err       <= 1'b1;
                err_state <= state;
            end
        end
    end

endmodule

// File: tb/tb_md_lr_seqr.sv
// Testbench for md_lr_seqr on a 4x4x4 grid with a 16-cycle watchdog.
// The expected behaviour is expressed as a timestep plan: NPTS clear
// writes, a WAIT of random length, then the list of phase codes each
// answered after a chosen number of cycles, with a hung phase expected to
// land in ERROR after exactly TMO_LIMIT cycles.
module tb_md_lr_seqr;

    localparam int GX        = 4;
    localparam int GY        = 4;
    localparam int GZ        = 4;
    localparam int NPTS      = GX * GY * GZ;
    localparam int AW        = $clog2(NPTS);
    localparam int STEP_W    = 16;
    localparam int TMO_W     = 20;
    localparam int TMO_LIMIT = 16;
    localparam int NONE      = 99;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [STEP_W-1:0] num_steps = '0;
    logic              skip_fcalc = 1'b0;
    logic              p_valid = 1'b0;
    logic              phase_done = 1'b0;
    logic [3:0]        state_o;
    logic              phase_start;
    logic              gm_clr_we;
    logic [AW-1:0]     gm_clr_addr;
    logic [STEP_W-1:0] step_cnt;
    logic              busy;
    logic              done;
    logic              err;
    logic [3:0]        err_state;

    int n_pass  = 0;
    int n_total = 0;

    md_lr_seqr #(
        .GX(GX), .GY(GY), .GZ(GZ), .STEP_W(STEP_W),
        .TMO_W(TMO_W), .TMO_LIMIT(TMO_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
        .skip_fcalc(skip_fcalc), .p_valid(p_valid), .phase_done(phase_done),
        .state_o(state_o), .phase_start(phase_start), .gm_clr_we(gm_clr_we),
        .gm_clr_addr(gm_clr_addr), .step_cnt(step_cnt), .busy(busy),
        .done(done), .err(err), .err_state(err_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One phase: phase_done is raised only on in-state cycle d (d=0 is the
    // ignored entry cycle). Without a later done the phase must time out.
    task automatic do_phase(input int code, input int d, output bit moved);
        moved = 1'b0;
        for (int k = 0; k < TMO_LIMIT; k++) begin
            check("ph_state", state_o, code);
            check("ph_start", phase_start, (k == 0));
            phase_done = (k == d);
            tick();
            phase_done = 1'b0;
            if (k == d && k != 0) begin
                moved = 1'b1;
                break;
            end
        end
    endtask

    // Full run from IDLE or ERROR. stall_code/stall_d override the done
    // timing of one phase in the first timestep; poke_start holds start high
    // with a different count throughout the first PGMAP.
    task automatic run(input int steps_req, input bit skip, input int stall_code,
                       input int stall_d, input bit poke_start);
        int eff;
        int nph;
        int w;
        int d;
        bit moved;
        eff = (steps_req == 0) ? 1 : steps_req;
        nph = skip ? 7 : 8;
        start      = 1'b1;
        num_steps  = STEP_W'(steps_req);
        skip_fcalc = skip;
        tick();
        start      = 1'b0;
        num_steps  = STEP_W'($urandom);
        skip_fcalc = 1'($urandom);
        check("start_err", err, 0);
        check("start_busy", busy, 1);
        for (int s = 0; s < eff; s++) begin
            check("step_cnt_init", step_cnt, s);
            for (int a = 0; a < NPTS; a++) begin
                check("init_state", state_o, 0);
                check("clr_we", gm_clr_we, 1);
                check("clr_addr", gm_clr_addr, a);
                tick();
            end
            w = $urandom_range(0, 4);
            for (int i = 0; i <= w; i++) begin
                check("wait_state", state_o, 1);
                check("wait_we", gm_clr_we, 0);
                p_valid = (i == w);
                tick();
            end
            p_valid = 1'b0;
            for (int j = 0; j < nph; j++) begin
                d = (s == 0 && (2 + j) == stall_code) ? stall_d : $urandom_range(1, 6);
                if (poke_start && s == 0 && j == 0) begin
                    start     = 1'b1;
                    num_steps = STEP_W'(eff + 3);
                end
                do_phase(2 + j, d, moved);
                start = 1'b0;
                if (!moved) begin
                    check("to_state", state_o, 4'hE);
                    check("to_err", err, 1);
                    check("to_err_state", err_state, 2 + j);
                    check("to_busy", busy, 0);
                    check("to_done", done, 0);
                    return;
                end
            end
            if (s == eff - 1) begin
                check("end_state", state_o, 4'hF);
                check("end_done", done, 1);
                check("end_step_cnt", step_cnt, eff);
                check("end_busy", busy, 0);
                tick();
                check("post_done", done, 0);
                check("post_state", state_o, 4'hF);
            end else begin
                check("mid_done", done, 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_state", state_o, 4'hF);
        check("rst_we", gm_clr_we, 0);
        check("rst_addr", gm_clr_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_step", step_cnt, 0);
        check("rst_err", {err, err_state, done, phase_start}, 0);
        rst_n = 1'b1;
        p_valid    = 1'b1;
        phase_done = 1'b1;
        repeat (3) begin
            tick();
            check("idle_hold", state_o, 4'hF);
        end
        p_valid    = 1'b0;
        phase_done = 1'b0;

        // Basic single step, then energy-only multi-step.
        run(1, 1'b0, NONE, 0, 1'b0);
        run(3, 1'b1, NONE, 0, 1'b0);

        // Hung FFTY: ERROR after 16 cycles, held until a new start.
        run(1, 1'b0, 4, 1000, 1'b0);
        p_valid    = 1'b1;
        phase_done = 1'b1;
        repeat (3) begin
            tick();
            check("err_hold_state", state_o, 4'hE);
            check("err_hold_flag", err, 1);
            check("err_hold_busy", busy, 0);
        end
        p_valid    = 1'b0;
        phase_done = 1'b0;
        run(2, 1'b0, NONE, 0, 1'b0);

        // Entry-cycle done in FFTX is ignored, so the watchdog fires there.
        run(1, 1'b0, 3, 0, 1'b0);

        // Done on the watchdog limit cycle of IFFTX wins; start during PGMAP
        // with a bigger count is ignored.
        run(2, 1'b0, 6, TMO_LIMIT - 1, 1'b1);

        // num_steps of zero runs one step.
        run(0, 1'b1, NONE, 0, 1'b0);

        // Reset mid-INIT at address 30.
        start     = 1'b1;
        num_steps = STEP_W'(2);
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("pre_rst_addr", gm_clr_addr, 30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", state_o, 4'hF);
        check("arst_we", gm_clr_we, 0);
        check("arst_addr", gm_clr_addr, 0);
        check("arst_done", done, 0);
        check("arst_step", step_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_idle", state_o, 4'hF);

        // Random runs.
        for (int r = 0; r < 3; r++) begin
            run($urandom_range(1, 3), 1'($urandom), NONE, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md_lr_seqr.md
Name: md_lr_seqr

Overview:
- Top-level phase sequencer for the long-range (PME) engine.
- Walks the te_md_lr_seqr_state phases INIT→WAIT→PGMAP→FFTX→FFTY→FFTZNG→IFFTX→IFFTY→IFFTZ→FCALC for a programmable number of timesteps.
- Drives grid-memory clearing directly and issues start/done handshakes to the phase engines.
- Adds what the plain state enum lacks: an IDLE and an ERROR state, an optional FCALC-skip mode, multi-step looping, and a per-phase watchdog.

Parameters:
- GX, 32, grid points along X
- GY, 32, grid points along Y
- GZ, 32, grid points along Z
- STEP_W, 16, width of timestep count
- TMO_W, 20, width of watchdog counter
- TMO_LIMIT, 2**20-1, watchdog limit in cycles; 0 disables the watchdog
- Derived: NPTS = GX*GY*GZ; AW = $clog2(NPTS)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request pulse
- num_steps  in  STEP_W  timesteps to run; latched on accepted start
- skip_fcalc  in  1  energy-only mode; latched on accepted start
- p_valid  in  1  first valid particle data available
- phase_done  in  1  completion pulse from the active phase engine
- state_o  out  4  current state, te_md_lr_seqr_state encoding
- phase_start  out  1  one-cycle pulse on entry to PGMAP..FCALC
- gm_clr_we  out  1  grid memory clear write enable
- gm_clr_addr  out  AW  grid memory clear address
- step_cnt  out  STEP_W  completed timesteps in the current run
- busy  out  1  high in every state except IDLE and ERROR
- done  out  1  one-cycle pulse when the run completes
- err  out  1  sticky watchdog error flag
- err_state  out  4  state that timed out

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state = IDLE (4'hF, RSVDSF slot). ERROR uses 4'hE (RSVDSE slot).
  - All outputs 0, except state_o = 4'hF.
- IDLE: start=1 → INIT. On that cycle latch num_steps (0 treated as 1) and skip_fcalc; clear step_cnt and err.
- start is ignored while busy=1.
- INIT:
  - gm_clr_we=1 every cycle; gm_clr_addr counts 0..NPTS-1, one address per cycle.
  - The cycle after the write to NPTS-1 → WAIT. INIT lasts exactly NPTS cycles.
  - gm_clr_we=0 and gm_clr_addr=0 in every other state.
- WAIT: p_valid=1 → PGMAP on the next cycle. No watchdog in WAIT.
- Phase states PGMAP..FCALC:
  - phase_start pulses on the first cycle in each state.
  - phase_done is ignored on the entry cycle and sampled on every later cycle.
  - A sampled phase_done moves the state to the successor on the next clock.
  - Order: PGMAP→FFTX→FFTY→FFTZNG→IFFTX→IFFTY→IFFTZ→FCALC.
- End of timestep, triggered by done from IFFTZ when skip_fcalc=1, otherwise by done from FCALC:
  - step_cnt increments.
  - If the new step_cnt equals the latched num_steps → IDLE with done pulse on the same clock edge.
  - Otherwise → INIT, which re-clears the grid for the next step.
- Watchdog:
  - Counter clears on every state entry and increments each cycle while in PGMAP..FCALC.
  - When it reaches TMO_LIMIT (TMO_LIMIT≠0) → ERROR. err=1 and err_state = offending state, both held.
  - phase_done arriving on the limit cycle wins: the transition happens and no error is raised.
- ERROR: busy=0. Left only by start (→ INIT, err cleared) or by reset.
- Codes 4'hA–4'hD are unreachable; any illegal state recovers to IDLE on the next clock.
- Reset mid-run aborts immediately. No done pulse; step_cnt = 0.

Test Plan:
- GX=GY=GZ=4, start with num_steps=1, p_valid at cycle 70, phase_done 5 cycles after each phase_start → 64 clear writes at addr 0..63; 8 phase_start pulses; done once; step_cnt=1; return to IDLE.
- num_steps=3, skip_fcalc=1 → INIT revisited 3 times; FCALC never entered; 7 phase_start pulses per step; done after step_cnt=3.
- TMO_LIMIT=16, phase_done withheld in FFTY → ERROR after 16 cycles in FFTY; err=1; err_state=4'h4; busy=0. A following start returns to INIT with err=0.
- phase_done asserted on the entry cycle of FFTX and never again → remains in FFTX (entry-cycle done ignored) until the watchdog fires.
- start pulsed during PGMAP and num_steps changed → ignored; run completes using the originally latched count.
- rst_n dropped mid-INIT at addr 30 → immediate IDLE with gm_clr_we=0; a new start restarts the clear from addr 0.
